mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Accumulate stage of the 16-bit MAC unit, directly downstream of the multiplier tree (mul_16x16 built from mul_8x8/mul_4x4).
//  Sums a frame of unsigned products into a wide accumulator, with optional saturation and a sticky overflow flag.
//  Presents each finished frame on a valid/ready result port that carries the sum, the term count and the overflow flag.
//  Accepts one product per cycle with no bubbles while a frame is open.
// PARAMETERS
//  PROD_W    32  product width from the multiplier; PROD_W <= ACC_W is required.
//  ACC_W     40  accumulator/result width.
//  CNT_W     8   width of the frame term counter.
//  SATURATE  1   1: clamp to 2^ACC_W-1 on overflow; 0: wrap modulo 2^ACC_W.
// PORTS
//  clk         in   1       rising-edge clock, sole clock domain.
//  rst         in   1       synchronous, active-high reset.
//  prod_valid  in   1       prod_data/prod_last valid this cycle.
//  prod_data   in   PROD_W  unsigned product from the multiplier.
//  prod_last   in   1       final term of the current frame.
//  prod_ready  out  1       stage can accept a product this cycle.
//  res_valid   out  1       result held and valid.
//  res_data    out  ACC_W   frame sum.
//  res_count   out  CNT_W   number of terms accepted in the frame (saturating).
//  res_ovf     out  1       at least one overflow occurred in the frame.
//  res_ready   in   1       downstream accepts the result.
//  busy        out  1       a frame is open (state ACC) or a result is pending (state DONE).
// BEHAVIOUR
//  - Transfer rules: a product is accepted on a cycle with prod_valid & prod_ready; a result is taken on a cycle with res_valid & res_ready.
//  - Reset: state<=IDLE; acc, count, ovf <= 0.
//    - Outputs during and after reset: res_valid=0, res_data=0, res_count=0, res_ovf=0, busy=0.
//    - prod_ready = ~rst & (state!=DONE), so it is 0 during the reset cycle.
//  - FSM states: IDLE, ACC, DONE. All outputs except prod_ready are registered or decoded from state.
//  - IDLE: on an accepted product: acc<=zext(prod_data); count<=1; ovf<=0.
//    - If prod_last is set, go to DONE; otherwise go to ACC.
//  - ACC: on an accepted product, compute sum = {1'b0,acc} + zext(prod_data) at ACC_W+1 bits.
//    - If sum[ACC_W]=1: ovf<=1, and acc<= SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0].
//    - Otherwise acc<=sum[ACC_W-1:0].
//    - count<=count+1, holding at 2^CNT_W-1.
//    - If prod_last is set, go to DONE.
//    - Idle cycles (prod_valid=0) leave all state unchanged.
//  - DONE: res_valid=1; res_data=acc, res_count=count, res_ovf=ovf, all held stable while res_ready=0.
//    - prod_ready=0 in DONE. Products offered here are not accepted and must be held by upstream.
//    - On res_ready: go to IDLE next cycle. There is one dead cycle before the next frame is accepted.
//  - Latency: last term accepted in cycle N -> res_valid=1 in cycle N+1.
//  - Once saturated, acc stays at all-ones for the rest of the frame and ovf stays 1.
//  - Reset mid-frame or mid-DONE discards the partial sum and any pending result; no res_valid is produced for that frame.
//  - A zero-valued product still counts as a term.
// TESTING (defaults unless noted)
//  1. Single-term frame: 0xE1 with prod_last -> next cycle res_valid=1, res_data=0xE1, res_count=1, res_ovf=0.
//  2. Four terms of 225 (15*15) on back-to-back cycles, last on the 4th -> res_data=0x384, res_count=4, prod_ready high throughout.
//  3. Backpressure: result pending, res_ready=0 for 5 cycles, prod_valid=1 -> res_* stable, prod_ready=0, no product consumed.
//     Then res_ready=1 -> IDLE, and the held product is accepted the following cycle.
//  4. Overflow: 257 terms of 0xFFFF_FFFF.
//     SATURATE=1 -> res_data=0xFF_FFFF_FFFF, res_ovf=1, res_count=257 mod-held at 255.
//     SATURATE=0 -> res_data=0x00_FFFF_FEFF, res_ovf=1.
//  5. Reset mid-frame: 3 terms, then rst for 1 cycle -> no res_valid.
//     Next frame 10, 20(last) -> res_data=30, res_count=2, res_ovf=0.
//  6. Bubbles: terms 1,2,3,4(last) with prod_valid low on alternate cycles -> res_data=10, res_count=4.

Source files
------------

// File: rtl/mac_accumulator.sv
// Accumulate stage of the 16-bit MAC: sums a frame of unsigned products into a wide
// accumulator with optional saturation, then holds the result on a valid/ready port.
module mac_accumulator #(
  parameter int          PROD_W   = 32,
  parameter int          ACC_W    = 40,
  parameter int          CNT_W    = 8,
  parameter int unsigned SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W:0]     sum;

  assign prod_ready = ~rst & (state_q != S_DONE);
  assign accept     = prod_valid & prod_ready;

  // One spare MSB captures the carry that signals overflow of the accumulator.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod_data);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(prod_data);
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = prod_last ? S_DONE : S_ACC;
        end
      end

      S_ACC: begin
        if (accept) begin
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
            acc_d = (SATURATE != 0) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          // Term count sticks at its maximum rather than wrapping.
          if (!(&count_q)) begin
            count_d = count_q + CNT_W'(1);
          end
          if (prod_last) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign res_count = count_q;
  assign res_ovf   = ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a saturating and a wrapping instance share stimulus;
// inputs change and outputs are sampled on the falling edge.
module tb_mac_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_valid;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;
  logic              res_ready;

  logic              s_prod_ready, s_res_valid, s_res_ovf, s_busy;
  logic [ACC_W-1:0]  s_res_data;
  logic [CNT_W-1:0]  s_res_count;
  logic              w_prod_ready, w_res_valid, w_res_ovf, w_busy;
  logic [ACC_W-1:0]  w_res_data;
  logic [CNT_W-1:0]  w_res_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_last(prod_last),
    .prod_ready(s_prod_ready),
    .res_valid(s_res_valid), .res_data(s_res_data), .res_count(s_res_count),
    .res_ovf(s_res_ovf), .res_ready(res_ready), .busy(s_busy)
  );

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_last(prod_last),
    .prod_ready(w_prod_ready),
    .res_valid(w_res_valid), .res_data(w_res_data), .res_count(w_res_count),
    .res_ovf(w_res_ovf), .res_ready(res_ready), .busy(w_busy)
  );

  task automatic drive(input logic v, input logic [PROD_W-1:0] d, input logic l);
    prod_valid = v;
    prod_data  = d;
    prod_last  = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    checks++;
    if ({s_prod_ready, w_prod_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_prod_ready: got %b expected 00", {s_prod_ready, w_prod_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({s_res_valid, s_busy, s_res_ovf, s_res_count, s_res_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {s_res_valid, s_busy, s_res_ovf, s_res_count, s_res_data});
    end
    checks++;
    if ({w_res_valid, w_busy, w_res_ovf, w_res_count, w_res_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_wrap: got %h expected 0",
               {w_res_valid, w_busy, w_res_ovf, w_res_count, w_res_data});
    end
    checks++;
    if ({s_prod_ready, w_prod_ready} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 11", {s_prod_ready, w_prod_ready});
    end
  endtask

  task automatic test_single();
    tick();
    drive(1'b1, 32'hE1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'hE1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_result: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'hE1, 8'd1, 1'b0});
    end
    checks++;
    if ({s_prod_ready, s_busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_done_flags: got %b expected 01", {s_prod_ready, s_busy});
    end
    release_result();
    checks++;
    if ({s_res_valid, s_busy, s_prod_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_release: got %b expected 001", {s_res_valid, s_busy, s_prod_ready});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_prod_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, s_prod_ready);
      end
      drive(1'b1, 32'd225, i == 3);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'h384, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'h384, 8'd4, 1'b0});
    end
    release_result();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'd5, 1'b1);
    tick();
    drive(1'b1, 32'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({s_res_valid, s_res_data, s_res_count, s_prod_ready} !== {1'b1, 40'd5, 8'd1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %h expected %h", i,
                 {s_res_valid, s_res_data, s_res_count, s_prod_ready}, {1'b1, 40'd5, 8'd1, 1'b0});
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({s_res_valid, s_prod_ready, s_res_data} !== {1'b0, 1'b1, 40'd5}) begin
      errors++;
      $display("FAIL bp_dead_cycle: got %h expected %h",
               {s_res_valid, s_prod_ready, s_res_data}, {1'b0, 1'b1, 40'd5});
    end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count} !== {1'b1, 40'd7, 8'd1}) begin
      errors++;
      $display("FAIL bp_held_product: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count}, {1'b1, 40'd7, 8'd1});
    end
    release_result();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 32'hFFFF_FFFF, i == 256);
      tick();
      if (i == 255) begin
        checks++;
        if ({s_res_data, s_res_count, s_res_ovf} !== {40'hFF_FFFF_FF00, 8'd255, 1'b0}) begin
          errors++;
          $display("FAIL ovf_edge_256: got %h expected %h",
                   {s_res_data, s_res_count, s_res_ovf}, {40'hFF_FFFF_FF00, 8'd255, 1'b0});
        end
      end
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'hFF_FFFF_FFFF, 8'd255, 1'b1}) begin
      errors++;
      $display("FAIL ovf_saturate: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'hFF_FFFF_FFFF, 8'd255, 1'b1});
    end
    checks++;
    if ({w_res_valid, w_res_data, w_res_count, w_res_ovf, w_busy, w_prod_ready} !==
        {1'b1, 40'h00_FFFF_FEFF, 8'd255, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_wrap: got %h expected %h",
               {w_res_valid, w_res_data, w_res_count, w_res_ovf, w_busy, w_prod_ready},
               {1'b1, 40'h00_FFFF_FEFF, 8'd255, 1'b1, 1'b1, 1'b0});
    end
    release_result();
  endtask

  task automatic test_reset_mid_frame();
    logic seen_valid;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 1), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (s_prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 0", s_prod_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({s_res_valid, s_busy, s_res_ovf, s_res_count, s_res_data} !== '0) begin
      errors++;
      $display("FAIL midrst_cleared: got %h expected 0",
               {s_res_valid, s_busy, s_res_ovf, s_res_count, s_res_data});
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_valid = seen_valid | s_res_valid;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result: got %b expected 0", seen_valid);
    end
    drive(1'b1, 32'd10, 1'b0);
    tick();
    drive(1'b1, 32'd20, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'd30, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL midrst_next_frame: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'd30, 8'd2, 1'b0});
    end
    release_result();
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 1), i == 3);
      tick();
      if (i < 3) begin
        drive(1'b0, '0, 1'b0);
        tick();
      end
      if (i == 1) begin
        checks++;
        if ({s_res_valid, s_busy, s_res_data, s_res_count} !== {1'b0, 1'b1, 40'd3, 8'd2}) begin
          errors++;
          $display("FAIL bubble_partial: got %h expected %h",
                   {s_res_valid, s_busy, s_res_data, s_res_count}, {1'b0, 1'b1, 40'd3, 8'd2});
        end
      end
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'd10, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL bubble_result: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'd10, 8'd4, 1'b0});
    end
    release_result();
  endtask

  task automatic test_zero_terms();
    drive(1'b1, 32'd0, 1'b0);
    tick();
    drive(1'b1, 32'd0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({s_res_valid, s_res_data, s_res_count, s_res_ovf} !== {1'b1, 40'd0, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL zero_terms: got %h expected %h",
               {s_res_valid, s_res_data, s_res_count, s_res_ovf}, {1'b1, 40'd0, 8'd2, 1'b0});
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_bubbles();
    test_zero_terms();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
